// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//
// Serializes one parallel word per Data_Valid handshake into a UART frame.
// The frame is a start bit (0), DATA_WIDTH data bits sent LSB first, an
// optional parity bit, and a stop bit (1). Each bit lasts Prescale clock
// cycles, and a Prescale of 0 is treated as 1.
//
// The parity bit matches the receiver's parity checker. PAR_TYP = 0 gives
// even parity (^data). PAR_TYP = 1 gives odd parity (~^data).
//
// Build option:
//   UART_TX_PARITY_EN  defined   : PARITY state, parity logic and the
//                                  PAR_EN/PAR_TYP latches are built.
//                      undefined : parity is compiled out. PAR_EN and
//                                  PAR_TYP are ignored, and every frame is
//                                  10 bit-times long.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-low reset
//   P_DATA     in   word to send, latched on acceptance
//   Data_Valid in   send request; only honoured in IDLE
//   PAR_EN     in   append a parity bit (latched on acceptance)
//   PAR_TYP    in   0 = even, 1 = odd (latched on acceptance)
//   Prescale   in   clock cycles per bit (latched on acceptance)
//   TX_OUT     out  serial line, registered, idles high
//   busy       out  registered, high for the whole frame
//
// State   | meaning
// --------+-----------------------------------------------
// IDLE    | line high, waiting for Data_Valid
// START   | driving the start bit (0)
// DATA    | driving data bit bit_idx
// PARITY  | driving the parity bit (parity builds only)
// STOP    | driving the stop bit (1), then back to IDLE

module uart_tx_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] timer;
  logic [PRESCALE_WIDTH-1:0] tc;       // terminal count = effective prescale - 1
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          idx_nxt;
  logic [DATA_WIDTH-1:0]     data_r;
  logic                      tc_hit;

`ifdef UART_TX_PARITY_EN
  logic par_en_r;
  logic par_bit;
`else
  // The parity ports stay on the boundary but drive nothing in this build.
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  assign tc_hit  = (timer == tc);
  assign idx_nxt = bit_idx + IDX_W'(1);

  // TX_OUT is loaded with the level of the state being entered. The line
  // therefore changes on the same edge as the state, with no combinational
  // path from the inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      TX_OUT  <= 1'b1;
      busy    <= 1'b0;
      timer   <= '0;
      tc      <= '0;
      bit_idx <= '0;
      data_r  <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_r <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            data_r  <= P_DATA;
            tc      <= (Prescale == '0) ? '0 : Prescale - 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            state   <= START;
            TX_OUT  <= 1'b0;
            busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_r <= PAR_EN;
            par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
`endif
          end
        end

        START: begin
          if (tc_hit) begin
            timer  <= '0;
            state  <= DATA;
            TX_OUT <= data_r[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DATA: begin
          if (tc_hit) begin
            timer <= '0;
            if (bit_idx == LAST_IDX) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_r) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
`else
              state  <= STOP;
              TX_OUT <= 1'b1;
`endif
            end else begin
              bit_idx <= idx_nxt;
              TX_OUT  <= data_r[idx_nxt];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tc_hit) begin
            timer  <= '0;
            state  <= STOP;
            TX_OUT <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        STOP: begin
          if (tc_hit) begin
            timer  <= '0;
            state  <= IDLE;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          timer  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd1;
  logic       TX_OUT;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         par_typ;
    int         p;
  } frame_t;

  frame_t sb[$];

  always #5 clk = ~clk;

  uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  function automatic int eff_p(input logic [5:0] p);
    return (p == 6'd0) ? 1 : int'(p);
  endfunction

  // Expected line level in cycle c (1-based, counted from the acceptance edge).
  function automatic logic exp_bit(input frame_t f, input int c);
    int b;
    b = (c - 1) / f.p;
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if (b == 9 && f.par_en) return f.par_typ ? ~^f.data : ^f.data;
    return 1'b1;
  endfunction

  function automatic int frame_len(input frame_t f);
    return (10 + (f.par_en ? 1 : 0)) * f.p;
  endfunction

  function automatic frame_t mk_frame(input logic [7:0] d, input bit pe,
                                      input bit pt, input logic [5:0] p);
    frame_t f;
    f.data    = d;
    f.par_en  = pe && HAS_PAR;
    f.par_typ = pt;
    f.p       = eff_p(p);
    return f;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: presents a request and records its frame.
  task automatic drive(input logic [7:0] d, input bit pe, input bit pt,
                       input logic [5:0] p);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = p;
    Data_Valid = 1'b1;
    sb.push_back(mk_frame(d, pe, pt, p));
  endtask

  // Waits for the acceptance edge, then checks every cycle of the frame and
  // the idle cycle after it. At cycle 5 the inputs change to the "next"
  // values and Data_Valid pulses. This must be ignored mid-frame, unless
  // keep_valid holds the request for a back-to-back frame.
  task automatic run_frame(input bit keep_valid, input logic [7:0] nd,
                           input bit npe, input bit npt, input logic [5:0] np,
                           input bit push_next);
    frame_t f;
    int n;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
      return;
    end
    f = sb.pop_front();
    n = frame_len(f);
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      check($sformatf("tx_%02h_c%0d", f.data, c), TX_OUT, exp_bit(f, c));
      check($sformatf("busy_%02h_c%0d", f.data, c), busy, 1'b1);
      if (c == 1) Data_Valid = keep_valid;
      if (c == 5) begin
        P_DATA     = nd;
        PAR_EN     = npe;
        PAR_TYP    = npt;
        Prescale   = np;
        Data_Valid = 1'b1;
        if (push_next) sb.push_back(mk_frame(nd, npe, npt, np));
      end
      if (c == 6) Data_Valid = keep_valid;
    end
    @(negedge clk);
    check($sformatf("idle_tx_%02h", f.data), TX_OUT, 1'b1);
    check($sformatf("idle_busy_%02h", f.data), busy, 1'b0);
  endtask

  initial begin
    frame_t fr;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // 0xA5 with no parity, 8 cycles per bit
    drive(8'hA5, 1'b0, 1'b0, 6'd8);
    run_frame(1'b0, 8'hFF, 1'b1, 1'b1, 6'd3, 1'b0);

    // parity type, even and then odd
    drive(8'hA5, 1'b1, 1'b0, 6'd8);
    run_frame(1'b0, 8'h00, 1'b0, 1'b1, 6'd1, 1'b0);
    drive(8'hA5, 1'b1, 1'b1, 6'd8);
    run_frame(1'b0, 8'h12, 1'b0, 1'b0, 6'd2, 1'b0);

    // parity value: 0x07 with even parity gives a parity bit of 1
    drive(8'h07, 1'b1, 1'b0, 6'd4);
    run_frame(1'b0, 8'hEE, 1'b0, 1'b1, 6'd9, 1'b0);

    // back-to-back frames with Data_Valid held high
    drive(8'h3C, 1'b0, 1'b0, 6'd4);
    run_frame(1'b1, 8'hC3, 1'b0, 1'b0, 6'd4, 1'b1);
    run_frame(1'b0, 8'h81, 1'b1, 1'b0, 6'd2, 1'b0);

    // reset asserted during data bit 3 (cycles 17..20 at P=4)
    fr = mk_frame(8'h5A, 1'b0, 1'b0, 6'd4);
    P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4;
    Data_Valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      check($sformatf("rstmid_tx_c%0d", c), TX_OUT, exp_bit(fr, c));
      if (c == 1) Data_Valid = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_tx_after", TX_OUT, 1'b1);
    check("rstmid_busy_after", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_tx_idle", TX_OUT, 1'b1);
    check("rstmid_busy_idle", busy, 1'b0);
    drive(8'h5A, 1'b0, 1'b0, 6'd4);
    run_frame(1'b0, 8'h00, 1'b0, 1'b0, 6'd1, 1'b0);

    // reset and Data_Valid on the same edge: reset wins
    rst = 1'b0;
    P_DATA = 8'h11;
    Data_Valid = 1'b1;
    @(negedge clk);
    check("rst_dv_tx", TX_OUT, 1'b1);
    check("rst_dv_busy", busy, 1'b0);
    rst = 1'b1;
    Data_Valid = 1'b0;
    @(negedge clk);
    check("rst_dv_tx_after", TX_OUT, 1'b1);
    check("rst_dv_busy_after", busy, 1'b0);

    // Prescale 0 and 1: one cycle per bit
    drive(8'hC6, 1'b0, 1'b0, 6'd0);
    run_frame(1'b0, 8'h3F, 1'b0, 1'b0, 6'd5, 1'b0);
    drive(8'h39, 1'b1, 1'b1, 6'd1);
    run_frame(1'b0, 8'hAA, 1'b0, 1'b0, 6'd7, 1'b0);

    // Every pushed frame must have been consumed.
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d entries expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer. It accepts one parallel byte per handshake and shifts it onto the serial line as a frame of start bit, 8 data bits LSB first, an optional parity bit, and a stop bit. Each bit lasts `Prescale` clock cycles. It is the transmit-side counterpart of the UART receiver: its frame format and parity convention match the receiver's parity checker exactly, so a loopback produces `par_error = 0`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: payload bits per frame. The test plan is written for 8.
- `PRESCALE_WIDTH`, default 6: width of the `Prescale` input.

Ports:
- `clk`, input, 1: single clock. Every register updates on its rising edge.
- `rst`, input, 1: reset. Synchronous and active-low.
- `P_DATA`, input, DATA_WIDTH: byte to transmit. Sampled only on acceptance.
- `Data_Valid`, input, 1: request to send `P_DATA`.
- `PAR_EN`, input, 1: when 1, a parity bit follows the data bits. Sampled on acceptance.
- `PAR_TYP`, input, 1: 0 selects even parity (`^data`); 1 selects odd parity (`~^data`). Sampled on acceptance.
- `Prescale`, input, PRESCALE_WIDTH: clock cycles per bit. Sampled on acceptance.
- `TX_OUT`, output, 1: serial line. Idles high.
- `busy`, output, 1: high for the whole frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance occurs in IDLE when `Data_Valid = 1`. At that edge the block:
  - latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`;
  - computes parity from the latched data;
  - moves to START.
- `Data_Valid` outside IDLE is ignored. There is no queueing and no error flag.
- Input changes after acceptance have no effect on the frame in flight.
- Bit timer: a counter runs from 0 to `Prescale`-1 in each bit state. At the terminal count it advances the state or bit index and wraps to 0.
  - `Prescale = 0` is treated as 1.
  - Timer width is PRESCALE_WIDTH. There is no overflow, because terminal count is at most 2^PRESCALE_WIDTH − 2.
- State transitions:
  - START → DATA.
  - DATA sends bit index 0..DATA_WIDTH-1, LSB first, using a 3-bit (clog2) index.
  - After the last data bit: DATA → PARITY if the latched `PAR_EN = 1`, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- `TX_OUT` levels: IDLE = 1, START = 0, DATA = current bit, PARITY = parity bit, STOP = 1.
- `TX_OUT` and `busy` are registered outputs with no combinational path from the inputs.
- Reset (`rst = 0` at an edge, including mid-frame):
  - state → IDLE;
  - `TX_OUT` → 1, `busy` → 0;
  - timer, bit index and data register → 0.
  - The partial frame is abandoned. There is no glitch low beyond the current cycle.

## Timing
- Acceptance edge is cycle 0.
- From cycle 1: `TX_OUT = 0` (start bit) and `busy = 1`.
- Data bit k occupies cycles 1+(k+1)·P through (k+2)·P, where P is the effective prescale.
- Frame length N = (DATA_WIDTH+2+PAR_EN)·P cycles, i.e. 10·P or 11·P. `busy` is high for exactly N cycles.
- At cycle N+1 the block is in IDLE: `busy = 0`, `TX_OUT = 1`.
  - If `Data_Valid = 1` in that cycle, the next frame's start bit appears at cycle N+2.
  - The minimum inter-frame idle is therefore one cycle of `TX_OUT = 1`.
- `rst` low and `Data_Valid` high at the same edge: reset wins and nothing is accepted.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined:
  - PARITY state, parity logic and the `PAR_EN`/`PAR_TYP` latches are present;
  - behaviour is as above.
- Undefined:
  - PARITY state and parity logic are compiled out;
  - `PAR_EN` and `PAR_TYP` remain as ports but are ignored;
  - every frame is 10·P cycles.

## Test plan
- No parity: `P_DATA = 0xA5`, `Prescale = 8`, `PAR_EN = 0`.
  - `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - `busy` high for 80 cycles.
- Parity type: `0xA5`, `PAR_EN = 1`.
  - `PAR_TYP = 0` → parity bit 0.
  - `PAR_TYP = 1` → parity bit 1.
  - Frame is 88 cycles in both cases.
- Parity value: `0x07`, even parity, `Prescale = 4` → parity bit 1. Looped into the receiver, its parity checker reports `par_error = 0`.
- Back-to-back and busy handshake:
  - Hold `Data_Valid` high continuously with `0x3C`, then `0xC3`. Each frame is accepted in the single IDLE cycle, with exactly one idle-high cycle between frames.
  - A `Data_Valid` pulse mid-frame is ignored.
- Reset mid-frame: assert `rst = 0` during data bit 3. Next cycle `TX_OUT = 1` and `busy = 0`. A new request then sends a full, correct frame.
- `Prescale = 0` and `Prescale = 1`: each bit lasts 1 cycle, and the 10-bit frame is correct.
